hilo_md_unit: RTL and testbench
===============================

Name: hilo_md_unit

Overview:
- E-stage multiply/divide responder for the HILOOp interface driven by the pipeline control decoder.
- Executes mult/multu/div/divu with fixed multi-cycle latency.
- Owns the HI/LO registers, serves mthi/mtlo writes and mfhi/mflo reads.
- Exports Start/Busy so the hazard unit stalls md/mf/mt instructions in D while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, Busy duration (cycles) for mult/multu; legal range 1..15.
- DIV_CYCLES, 10, Busy duration (cycles) for div/divu; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- HILOOp  input  4  E-stage op code, shared macro constants: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9..15 treated as none.
- A  input  32  forwarded rs value.
- B  input  32  forwarded rt value.
- Start  output  1  combinational: HILOOp is 1..4 and unit is idle.
- Busy  output  1  registered: operation in flight.
- HILOOut  output  32  combinational: HI when mfhi, LO when mflo, else 0.

Behaviour:
- Reset (synchronous, active-high): HI=0, LO=0, Busy=0, counter=0, pending result cleared. Reset mid-operation discards the pending result; HI/LO become 0.
- Idle (Busy=0), md op in cycle T:
  - Start=1 in T.
  - At the T edge: compute the 64-bit result from A/B into pending registers, load counter with MULT_CYCLES or DIV_CYCLES, set Busy=1.
- Busy phase:
  - Counter decrements each edge.
  - On the edge where counter==1: commit pending to HI/LO, set Busy=0.
  - Busy is therefore high for exactly N cycles (T+1..T+N); new HI/LO visible from T+N+1.
- Arithmetic:
  - mult: signed 32x32 -> {HI,LO} 64-bit product.
  - multu: same, unsigned.
  - div: LO = quotient truncated toward zero; HI = remainder, sign of dividend.
  - divu: LO/HI = unsigned quotient/remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (div or divu): full Busy duration; HI/LO unchanged at commit.
- mthi/mtlo while idle: HI or LO <= A at that edge; readable the next cycle.
- While Busy, any HILOOp (md, mt, mf) is ignored: no restart, no write. mfhi/mflo still output the old HI/LO. The hazard unit prevents this case; the unit's behaviour is defined regardless.
- An md op arriving on the same cycle as the commit edge (Busy=1) is ignored. It is accepted in the following cycle, when Busy=0.
- HILOOut is purely combinational from the HI/LO registers. No forwarding of an in-flight result.
- Start never asserts while Busy=1.

Decomposition:
- HILO_* op constants live in the shared macro header alongside the ALU/DM/NPC constants. MULT_CYCLES and DIV_CYCLES defaults are also defined there.
- No sub-module is required. Arithmetic uses inline signed/unsigned operators into the pending registers.
- Control is a two-state idle/busy machine encoded by Busy plus a 4-bit down-counter.

Test Plan:
- Reset, then mfhi and mflo -> HILOOut=0 both; Busy=0.
- mult A=0xFFFFFFFE (-2), B=3 -> Start=1 one cycle, Busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9 (-7), B=2 -> Busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 -> LO=3, HI=1.
- mthi A=0x12345678, then divu A=5, B=0 -> Busy 10 cycles; HI stays 0x12345678 and LO stays unchanged after commit.
- Issue mult, then mtlo A=0xDEAD and a second mult at busy cycles 2 and 3 -> both ignored; result equals the first mult only; Start stays 0 while Busy.
- Reset asserted at busy cycle 3 of a mult -> next cycle Busy=0, HI=LO=0, no later commit.

Source files
------------

// File: rtl/hilo_md_unit_pkg.sv
// ============================================================================
// Module : hilo_md_unit_pkg
// Brief  : HILOOp encodings and default multiply/divide latencies.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hilo_md_unit_pkg;

  localparam logic [3:0] HILO_NONE  = 4'd0;
  localparam logic [3:0] HILO_MULT  = 4'd1;
  localparam logic [3:0] HILO_MULTU = 4'd2;
  localparam logic [3:0] HILO_DIV   = 4'd3;
  localparam logic [3:0] HILO_DIVU  = 4'd4;
  localparam logic [3:0] HILO_MFHI  = 4'd5;
  localparam logic [3:0] HILO_MFLO  = 4'd6;
  localparam logic [3:0] HILO_MTHI  = 4'd7;
  localparam logic [3:0] HILO_MTLO  = 4'd8;

  localparam int unsigned DEF_MULT_CYCLES = 5;
  localparam int unsigned DEF_DIV_CYCLES  = 10;

  function automatic logic is_md_op(input logic [3:0] op);
    return (op >= HILO_MULT) && (op <= HILO_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hilo_md_unit.sv
// ============================================================================
// Module : hilo_md_unit
// Brief  : E-stage multiply/divide unit owning HI/LO, fixed-latency Busy.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hilo_md_unit
  import hilo_md_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  HILOOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HILOOut
);

  localparam logic [3:0] MULT_LOAD = MULT_CYCLES[3:0];
  localparam logic [3:0] DIV_LOAD  = DIV_CYCLES[3:0];

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        div0_q, div0_d;
  logic        busy_q, busy_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, den_u, den_m;
  logic [31:0] quo_u, rem_u, quo_m, rem_m, quo_s, rem_s;

  // Signed divide works on magnitudes, so 0x80000000 / -1 needs no special case.
  always_comb begin
    prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prod_u = {32'd0, A} * {32'd0, B};
    a_neg  = A[31];
    b_neg  = B[31];
    a_mag  = a_neg ? -A : A;
    b_mag  = b_neg ? -B : B;
    den_u  = (B == 32'd0) ? 32'd1 : B;
    den_m  = (B == 32'd0) ? 32'd1 : b_mag;
    quo_u  = A / den_u;
    rem_u  = A % den_u;
    quo_m  = a_mag / den_m;
    rem_m  = a_mag % den_m;
    quo_s  = (a_neg ^ b_neg) ? -quo_m : quo_m;
    rem_s  = a_neg ? -rem_m : rem_m;
  end

  assign Start = is_md_op(HILOOp) && !busy_q;
  assign Busy  = busy_q;

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    div0_d    = div0_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    if (!busy_q) begin
      if (Start) begin
        busy_d = 1'b1;
        div0_d = 1'b0;
        unique case (HILOOp)
          HILO_MULT: begin
            {pend_hi_d, pend_lo_d} = prod_s;
            cnt_d                  = MULT_LOAD;
          end
          HILO_MULTU: begin
            {pend_hi_d, pend_lo_d} = prod_u;
            cnt_d                  = MULT_LOAD;
          end
          HILO_DIV: begin
            pend_hi_d = rem_s;
            pend_lo_d = quo_s;
            div0_d    = (B == 32'd0);
            cnt_d     = DIV_LOAD;
          end
          default: begin
            pend_hi_d = rem_u;
            pend_lo_d = quo_u;
            div0_d    = (B == 32'd0);
            cnt_d     = DIV_LOAD;
          end
        endcase
      end else if (HILOOp == HILO_MTHI) begin
        hi_d = A;
      end else if (HILOOp == HILO_MTLO) begin
        lo_d = A;
      end
    end else begin
      // Every op is dropped while busy; the commit edge is the last busy edge.
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        busy_d = 1'b0;
        if (!div0_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      div0_q    <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= 4'd0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      div0_q    <= div0_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    HILOOut = 32'd0;
    if (HILOOp == HILO_MFHI)      HILOOut = hi_q;
    else if (HILOOp == HILO_MFLO) HILOOut = lo_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_hilo_md_unit.sv
// ============================================================================
// Module : tb_hilo_md_unit
// Brief  : Scoreboard bench for hilo_md_unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hilo_md_unit;
  import hilo_md_unit_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  HILOOp;
  logic [31:0] A, B;
  logic        Start, Busy;
  logic [31:0] HILOOut;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        sb[$];
  logic [31:0] model_hi, model_lo;

  hilo_md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .HILOOp(HILOOp), .A(A), .B(B),
    .Start(Start), .Busy(Busy), .HILOOut(HILOOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_md(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] hi,
                                         input logic [31:0] lo);
    longint sa, sb2, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    case (op)
      HILO_MULT:  begin q = sa * sb2; p = q; return p; end
      HILO_MULTU: return {32'd0, a} * {32'd0, b};
      HILO_DIV: begin
        if (b == 32'd0) return {hi, lo};
        q = sa / sb2;
        r = sa % sb2;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {hi, lo};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    HILOOp = HILO_MFHI; #1;
    check({tag, "_hi"}, HILOOut, exp_hi);
    HILOOp = HILO_MFLO; #1;
    check({tag, "_lo"}, HILOOut, exp_lo);
    HILOOp = HILO_NONE;
  endtask

  // inject: 1 = mtlo/mult during busy cycles 2,3; 2 = md op on the commit cycle
  task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int inject);
    int   n;
    int   n_exp;
    exp_t e;
    n_exp  = (op == HILO_MULT || op == HILO_MULTU) ? 5 : 10;
    HILOOp = op; A = a; B = b; #1;
    check({tag, "_start"}, {31'd0, Start}, 32'd1);
    e.hi = exp_hi; e.lo = exp_lo;
    sb.push_back(e);
    tick();
    HILOOp = HILO_NONE;
    n = 0;
    while (Busy && n < 40) begin
      n++;
      if (inject == 1 && n == 2) begin
        HILOOp = HILO_MTLO; A = 32'h0000DEAD; #1;
        check({tag, "_start_mt"}, {31'd0, Start}, 32'd0);
      end
      if (inject == 1 && n == 3) begin
        HILOOp = HILO_MULT; A = 32'd100; B = 32'd100; #1;
        check({tag, "_start_busy"}, {31'd0, Start}, 32'd0);
      end
      if (inject == 2 && n == n_exp) begin
        HILOOp = HILO_MULTU; A = 32'd9; B = 32'd9; #1;
        check({tag, "_start_commit"}, {31'd0, Start}, 32'd0);
      end
      tick();
      HILOOp = HILO_NONE;
    end
    check({tag, "_busy_len"}, n, n_exp);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      read_hilo(tag, e.hi, e.lo);
      model_hi = e.hi;
      model_lo = e.lo;
    end
  endtask

  initial begin
    logic [63:0] r;
    logic [3:0]  op;
    logic [31:0] ra, rb;
    reset = 1'b1; HILOOp = HILO_NONE; A = 32'd0; B = 32'd0;
    tick(); tick();
    reset = 1'b0;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_start", {31'd0, Start}, 32'd0);
    read_hilo("rst", 32'd0, 32'd0);
    model_hi = 32'd0; model_lo = 32'd0;

    run_md("mult",  HILO_MULT,  32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 0);
    run_md("multu", HILO_MULTU, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 0);
    run_md("div",   HILO_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run_md("divu",  HILO_DIVU,  32'd7,        32'd2, 32'd1,        32'd3,        0);

    HILOOp = HILO_MTHI; A = 32'h12345678;
    tick();
    HILOOp = HILO_NONE;
    read_hilo("mthi", 32'h12345678, 32'd3);
    model_hi = 32'h12345678;
    run_md("divu0", HILO_DIVU, 32'd5, 32'd0, 32'h12345678, 32'd3, 0);

    run_md("ovf", HILO_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 2);
    check("after_commit_busy", {31'd0, Busy}, 32'd0);
    run_md("ign", HILO_MULT, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1);

    for (int i = 0; i < 8; i++) begin
      op = 4'($urandom_range(1, 4));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
      r  = ref_md(op, ra, rb, model_hi, model_lo);
      run_md("rnd", op, ra, rb, r[63:32], r[31:0], 0);
    end

    HILOOp = HILO_MULT; A = 32'd6; B = 32'd7;
    tick();
    HILOOp = HILO_NONE;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy", {31'd0, Busy}, 32'd0);
    read_hilo("mid_rst", 32'd0, 32'd0);
    repeat (8) tick();
    check("mid_rst_late_busy", {31'd0, Busy}, 32'd0);
    read_hilo("mid_rst_late", 32'd0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
